// File: rtl/instr_fetch_reg_if.sv
// Handshake bundle between the control unit / instruction memory and the
// instruction fetch register. The slave modport is the fetch register's view.
interface instr_fetch_reg_if;
  logic        fetch;
  logic        consume;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        mem_req;
  logic [15:0] ir;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [7:0]  imm8;

  modport master (
    output fetch,
    output consume,
    output mem_ready,
    output mem_data,
    input  mem_req,
    input  ir,
    input  ir_valid,
    input  busy,
    input  fetch_err,
    input  opcode,
    input  rd,
    input  rs,
    input  rt,
    input  imm8
  );

  modport slave (
    input  fetch,
    input  consume,
    input  mem_ready,
    input  mem_data,
    output mem_req,
    output ir,
    output ir_valid,
    output busy,
    output fetch_err,
    output opcode,
    output rd,
    output rs,
    output rt,
    output imm8
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction register and fetch sequencer: runs the memory req/ready handshake,
// holds the fetched word until consumed, and bounds each memory wait with a timeout.
module instr_fetch_reg #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                     CLK,
  input logic                     Reset,
  instr_fetch_reg_if.slave        bus
);

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StValid,
    StError
  } state_e;

  state_e      r_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_ir;
  logic        r_mem_req;
  logic        r_ir_valid;
  logic        r_busy;
  logic        r_fetch_err;

  // Outputs are registered alongside the state so no input reaches an output
  // combinationally.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 8'd0;
      r_ir        <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.fetch) begin
            r_state    <= StWait;
            r_wait_cnt <= 8'd0;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        StWait: begin
          // Data wins over the timeout when both land on the same cycle.
          if (bus.mem_ready) begin
            r_ir       <= bus.mem_data;
            r_state    <= StValid;
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_ir_valid <= 1'b1;
          end else if (r_wait_cnt == LastCnt) begin
            r_state     <= StError;
            r_mem_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        StValid: begin
          if (bus.consume) begin
            r_ir_valid <= 1'b0;
            if (bus.fetch) begin
              r_state    <= StWait;
              r_wait_cnt <= 8'd0;
              r_mem_req  <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end

        StError: begin
          if (bus.fetch) begin
            r_state     <= StWait;
            r_wait_cnt  <= 8'd0;
            r_fetch_err <= 1'b0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.ir        = r_ir;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.busy      = r_busy;
  assign bus.fetch_err = r_fetch_err;
  assign bus.opcode    = r_ir[15:12];
  assign bus.rd        = r_ir[11:8];
  assign bus.rs        = r_ir[7:4];
  assign bus.rt        = r_ir[3:0];
  assign bus.imm8      = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg with a scoreboard of expected captured words
// checked by a separate monitor whenever ir_valid rises.
module tb_instr_fetch_reg;

  typedef struct packed {
    logic [15:0] ir;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [7:0]  imm;
  } exp_t;

  logic CLK;
  logic Reset;
  int   checks;
  int   failures;
  exp_t q[$];
  logic prev_valid;

  instr_fetch_reg_if bus ();

  instr_fetch_reg #(
    .TIMEOUT (4)
  ) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt, input logic [7:0] imm);
    exp_t e;
    e.ir  = w;
    e.op  = op;
    e.rd  = rd;
    e.rs  = rs;
    e.rt  = rt;
    e.imm = imm;
    q.push_back(e);
  endtask

  // Monitor: compare each newly presented instruction against the scoreboard.
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (!Reset && bus.ir_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_capture: got ir=%0h expected none", bus.ir);
        end else begin
          e = q.pop_front();
          chk("mon_ir", 32'(bus.ir), 32'(e.ir));
          chk("mon_opcode", 32'(bus.opcode), 32'(e.op));
          chk("mon_rd", 32'(bus.rd), 32'(e.rd));
          chk("mon_rs", 32'(bus.rs), 32'(e.rs));
          chk("mon_rt", 32'(bus.rt), 32'(e.rt));
          chk("mon_imm8", 32'(bus.imm8), 32'(e.imm));
          chk("mon_mem_req_low", 32'(bus.mem_req), 32'd0);
          chk("mon_busy_low", 32'(bus.busy), 32'd0);
        end
      end
      prev_valid = bus.ir_valid;
    end
  end

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    Reset         = 1'b1;
    bus.fetch     = 1'b0;
    bus.consume   = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 16'h0000;

    // Reset state
    step();
    step();
    Reset = 1'b0;
    step();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    chk("rst_ir", 32'(bus.ir), 32'h0000);
    chk("rst_imm8", 32'(bus.imm8), 32'h00);

    // Basic fetch, ready on the 3rd request cycle
    bus.mem_data = 16'h3A5C;
    push(16'h3A5C, 4'h3, 4'hA, 4'h5, 4'hC, 8'h5C);
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    chk("fetch_mem_req", 32'(bus.mem_req), 32'd1);
    chk("fetch_busy", 32'(bus.busy), 32'd1);
    step();
    step();
    chk("fetch_req_3rd", 32'(bus.mem_req), 32'd1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("basic_ir_valid", 32'(bus.ir_valid), 32'd1);
    chk("basic_ir", 32'(bus.ir), 32'h3A5C);

    // Hold: fetch without consume is ignored
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    chk("hold_no_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("hold_no_req2", 32'(bus.mem_req), 32'd0);
    chk("hold_ir", 32'(bus.ir), 32'h3A5C);
    chk("hold_valid", 32'(bus.ir_valid), 32'd1);

    // Back-to-back: consume + fetch together
    bus.mem_data = 16'hF0FF;
    push(16'hF0FF, 4'hF, 4'h0, 4'hF, 4'hF, 8'hFF);
    bus.fetch   = 1'b1;
    bus.consume = 1'b1;
    step();
    bus.fetch   = 1'b0;
    bus.consume = 1'b0;
    chk("b2b_valid_drop", 32'(bus.ir_valid), 32'd0);
    chk("b2b_mem_req", 32'(bus.mem_req), 32'd1);
    chk("b2b_ir_kept", 32'(bus.ir), 32'h3A5C);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("b2b_ir", 32'(bus.ir), 32'hF0FF);
    bus.consume = 1'b1;
    step();
    bus.consume = 1'b0;
    chk("consume_valid", 32'(bus.ir_valid), 32'd0);
    chk("consume_no_req", 32'(bus.mem_req), 32'd0);

    // Timeout with TIMEOUT = 4
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.mem_req) break;
      n++;
      step();
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_err", 32'(bus.fetch_err), 32'd1);
    chk("timeout_req_low", 32'(bus.mem_req), 32'd0);
    chk("timeout_busy_low", 32'(bus.busy), 32'd0);
    chk("timeout_ir_kept", 32'(bus.ir), 32'hF0FF);

    // Retry from ERROR
    bus.mem_data = 16'h1234;
    push(16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 8'h34);
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    chk("retry_err_clear", 32'(bus.fetch_err), 32'd0);
    chk("retry_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("retry_ir", 32'(bus.ir), 32'h1234);
    bus.consume = 1'b1;
    step();
    bus.consume = 1'b0;

    // Ready on the last allowed request cycle
    bus.mem_data = 16'h8001;
    push(16'h8001, 4'h8, 4'h0, 4'h0, 4'h1, 8'h01);
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    step();
    step();
    step();
    chk("bound_req_4th", 32'(bus.mem_req), 32'd1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("bound_ir", 32'(bus.ir), 32'h8001);
    chk("bound_no_err", 32'(bus.fetch_err), 32'd0);
    chk("bound_valid", 32'(bus.ir_valid), 32'd1);
    bus.consume = 1'b1;
    step();
    bus.consume = 1'b0;

    // Reset mid-WAIT, late ready ignored
    bus.fetch = 1'b1;
    step();
    bus.fetch = 1'b0;
    step();
    chk("rstw_req_2nd", 32'(bus.mem_req), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rstw_req_low", 32'(bus.mem_req), 32'd0);
    chk("rstw_ir_zero", 32'(bus.ir), 32'h0000);
    bus.mem_data  = 16'hBEEF;
    bus.mem_ready = 1'b1;
    step();
    step();
    bus.mem_ready = 1'b0;
    chk("rstw_ir_still_zero", 32'(bus.ir), 32'h0000);
    chk("rstw_no_valid", 32'(bus.ir_valid), 32'd0);
    chk("rstw_no_req", 32'(bus.mem_req), 32'd0);

    step();
    step();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
